// File: rtl/ar_issue_mux.sv
// ar_issue_mux: latches one granted master AR request and presents it to the selected slave.
// Latency: grant sampled at edge N -> AR_ready_f pulse and S_ARVALID in cycle N+1; at most one request per 2 cycles.
// Backpressure: S_ARVALID/payload held until S_ARREADY; grants in ISSUE or for a full master are ignored.
//
// Ports:
//   clk, clr (async active-low reset)
//   AR_grant_f/AR_sel_f/AR_addr_f/AR_id_f : per-master grant and request payload from the arbiter
//   R_done_f    : per-master read completion pulse (frees one outstanding slot)
//   AR_ready_f  : one-cycle accept pulse to the loaded master
//   S_ARVALID/S_ARREADY/S_ARADDR/S_ARID : per-slave AR channel, ARID = {master index, master ID}
//   AR_full_f   : master has NUM_OUTSTANDING_TRANS reads outstanding
//   AR_busy     : ISSUE state active; AR_timeout_f : watchdog drop pulse
// Optional feature: define AR_ISSUE_TIMEOUT_EN to enable the ISSUE watchdog (TIMEOUT cycles).
module ar_issue_mux #(
  parameter int M                     = 2,
  parameter int S                     = 2,
  parameter int NUM_OUTSTANDING_TRANS = 2,
  parameter int ADDR_WIDTH            = 32,
  parameter int TIMEOUT               = 16,
  localparam int SW  = (S > 1) ? $clog2(S) : 1,
  localparam int MW  = (M > 1) ? $clog2(M) : 1,
  localparam int IDW = (NUM_OUTSTANDING_TRANS > 1) ? $clog2(NUM_OUTSTANDING_TRANS) : 1,
  localparam int CW  = $clog2(NUM_OUTSTANDING_TRANS + 1)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [M-1:0]             AR_grant_f,
  input  logic [M*SW-1:0]          AR_sel_f,
  input  logic [M*ADDR_WIDTH-1:0]  AR_addr_f,
  input  logic [M*IDW-1:0]         AR_id_f,
  input  logic [M-1:0]             R_done_f,
  output logic [M-1:0]             AR_ready_f,
  output logic [S-1:0]             S_ARVALID,
  input  logic [S-1:0]             S_ARREADY,
  output logic [S*ADDR_WIDTH-1:0]  S_ARADDR,
  output logic [S*(MW+IDW)-1:0]    S_ARID,
  output logic [M-1:0]             AR_full_f,
  output logic                     AR_busy,
  output logic                     AR_timeout_f
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [MW-1:0]         r_mst;
  logic [SW-1:0]         r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [IDW-1:0]        r_id;
  logic [M-1:0]          r_ready;
  logic [CW-1:0]         r_cnt [M];

  logic                  w_load;
  logic [MW-1:0]         w_load_idx;
  logic                  w_hs;
  logic                  w_tmo;
  logic [M-1:0]          w_full;
  logic [M-1:0]          w_inc;
  logic [M-1:0]          w_dec;
  logic [S-1:0]          w_arvalid;

  always_comb begin
    w_full = '0;
    for (int i = 0; i < M; i++) w_full[i] = (r_cnt[i] == CW'(NUM_OUTSTANDING_TRANS));
  end

  // Lowest-index granted master that still has a free outstanding slot wins; only loads from IDLE.
  always_comb begin
    w_load     = 1'b0;
    w_load_idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (AR_grant_f[i] && !w_full[i]) begin
        w_load     = 1'b1;
        w_load_idx = MW'(i);
      end
    end
    if (r_state != ST_IDLE) w_load = 1'b0;
  end

  always_comb begin
    w_arvalid = '0;
    if (r_state == ST_ISSUE)
      for (int s = 0; s < S; s++) w_arvalid[s] = (r_sel == SW'(s));
  end

  // Masking ARREADY with our own ARVALID keeps an out-of-range select from ever completing.
  assign w_hs = |(S_ARREADY & w_arvalid);

`ifdef AR_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;

  // r_tmo_cnt holds (ISSUE cycles elapsed - 1); a handshake in the last allowed cycle still wins.
  assign w_tmo = (r_state == ST_ISSUE) && !w_hs && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      if (r_state == ST_ISSUE && !w_hs && !w_tmo) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                                        r_tmo_cnt <= '0;
    end
  end

  assign AR_timeout_f = r_timeout;
`else
  // Watchdog compiled out: ISSUE waits for the handshake indefinitely (expression is constant 0).
  assign w_tmo        = (TIMEOUT < 0);
  assign AR_timeout_f = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_load)         w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_hs || w_tmo)  w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_mst   <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_id    <= '0;
      r_ready <= '0;
    end else begin
      r_ready <= '0;
      if (w_load) begin
        r_mst               <= w_load_idx;
        r_sel               <= AR_sel_f[w_load_idx*SW +: SW];
        r_addr              <= AR_addr_f[w_load_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_id                <= AR_id_f[w_load_idx*IDW +: IDW];
        r_ready[w_load_idx] <= 1'b1;
      end
    end
  end

  // Outstanding counters: a read counts once the slave accepts it; completion at zero is ignored.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < M; i++) begin
      w_inc[i] = w_hs && (r_mst == MW'(i)) && !w_full[i];
      w_dec[i] = R_done_f[i] && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < M; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_inc[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    S_ARADDR = '0;
    S_ARID   = '0;
    for (int s = 0; s < S; s++) begin
      if (w_arvalid[s]) begin
        S_ARADDR[s*ADDR_WIDTH +: ADDR_WIDTH] = r_addr;
        S_ARID[s*(MW+IDW) +: (MW+IDW)]       = {r_mst, r_id};
      end
    end
  end

  assign S_ARVALID  = w_arvalid;
  assign AR_ready_f = r_ready;
  assign AR_full_f  = w_full;
  assign AR_busy    = (r_state == ST_ISSUE);

endmodule

// File: tb/tb_ar_issue_mux.sv
module tb_ar_issue_mux;
  localparam int M   = 2;
  localparam int S   = 2;
  localparam int NOT = 2;
  localparam int AW  = 32;
  localparam int TMO = 16;
  localparam int SW  = 1;
  localparam int MW  = 1;
  localparam int IDW = 1;
  localparam int IW  = MW + IDW;
`ifdef AR_ISSUE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr;
  logic [M-1:0]      AR_grant_f;
  logic [M*SW-1:0]   AR_sel_f;
  logic [M*AW-1:0]   AR_addr_f;
  logic [M*IDW-1:0]  AR_id_f;
  logic [M-1:0]      R_done_f;
  logic [M-1:0]      AR_ready_f;
  logic [S-1:0]      S_ARVALID;
  logic [S-1:0]      S_ARREADY;
  logic [S*AW-1:0]   S_ARADDR;
  logic [S*IW-1:0]   S_ARID;
  logic [M-1:0]      AR_full_f;
  logic              AR_busy;
  logic              AR_timeout_f;

  int total = 0;
  int bad   = 0;

  // Reference model: the single in-flight request plus per-master outstanding read counts.
  bit             m_busy;
  int             m_mst, m_sel, m_age;
  logic [AW-1:0]  m_addr;
  logic [IDW-1:0] m_id;
  logic [M-1:0]   m_ready;
  bit             m_tmo;
  int             m_cnt [M];

  ar_issue_mux #(.M(M), .S(S), .NUM_OUTSTANDING_TRANS(NOT), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .AR_grant_f(AR_grant_f), .AR_sel_f(AR_sel_f), .AR_addr_f(AR_addr_f),
    .AR_id_f(AR_id_f), .R_done_f(R_done_f), .AR_ready_f(AR_ready_f), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_ARADDR(S_ARADDR), .S_ARID(S_ARID), .AR_full_f(AR_full_f),
    .AR_busy(AR_busy), .AR_timeout_f(AR_timeout_f));

  always #5 clk = ~clk;

  task automatic model_clear();
    m_busy = 0; m_mst = 0; m_sel = 0; m_age = 0; m_addr = '0; m_id = '0; m_ready = '0; m_tmo = 0;
    for (int i = 0; i < M; i++) m_cnt[i] = 0;
  endtask

  task automatic drive_idle();
    AR_grant_f = '0; AR_sel_f = '0; AR_addr_f = '0; AR_id_f = '0; R_done_f = '0; S_ARREADY = '0;
  endtask

  // Called at a falling edge with inputs set: advances model and DUT one rising edge, returns at next falling edge.
  task automatic step();
    int             ld = -1;
    bit             hs = 0, to = 0;
    int             nc [M];
    int             l_sel;
    logic [AW-1:0]  l_addr;
    logic [IDW-1:0] l_id;
    l_sel = 0; l_addr = '0; l_id = '0;
    if (m_busy) begin
      if (S_ARREADY[m_sel]) hs = 1;
      else if (TMO_EN && m_age == TMO - 1) to = 1;
    end else begin
      for (int i = M - 1; i >= 0; i--) if (AR_grant_f[i] && m_cnt[i] < NOT) ld = i;
    end
    if (ld >= 0) begin
      l_sel  = int'(AR_sel_f[ld*SW +: SW]);
      l_addr = AR_addr_f[ld*AW +: AW];
      l_id   = AR_id_f[ld*IDW +: IDW];
    end
    for (int i = 0; i < M; i++) begin
      nc[i] = m_cnt[i];
      if (hs && m_mst == i) nc[i]++;
      if (R_done_f[i] && m_cnt[i] > 0) nc[i]--;
    end
    @(posedge clk);
    m_cnt = nc; m_tmo = to; m_ready = '0;
    if (ld >= 0) begin
      m_busy = 1; m_mst = ld; m_sel = l_sel; m_addr = l_addr; m_id = l_id; m_age = 0; m_ready[ld] = 1'b1;
    end else if (hs || to) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle(); clr = 1'b0; model_clear();
    @(negedge clk); @(negedge clk);
    total++; if (AR_ready_f !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", AR_ready_f); end
    total++; if (S_ARVALID !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", S_ARVALID); end
    total++; if (S_ARADDR !== '0 || S_ARID !== '0) begin bad++; $display("FAIL reset_payload addr=%h id=%h want 0", S_ARADDR, S_ARID); end
    total++; if (AR_full_f !== 2'b00 || AR_busy !== 1'b0 || AR_timeout_f !== 1'b0) begin
      bad++; $display("FAIL reset_status full=%b busy=%b tmo=%b want 00/0/0", AR_full_f, AR_busy, AR_timeout_f); end
    clr = 1'b1;
    step();
    total++; if (S_ARVALID !== 2'b00 || AR_busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle valid=%b busy=%b", S_ARVALID, AR_busy); end
  endtask

  task automatic test_single();
    AR_grant_f = 2'b01; AR_sel_f = 2'b01; AR_addr_f = {32'h0, 32'hA000_0000}; AR_id_f = 2'b00; S_ARREADY = 2'b10;
    step();
    total++; if (AR_ready_f !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", AR_ready_f); end
    total++; if (S_ARVALID !== 2'b10) begin bad++; $display("FAIL single_valid got=%b want=10", S_ARVALID); end
    total++; if (S_ARADDR !== {32'hA000_0000, 32'h0}) begin bad++; $display("FAIL single_addr got=%h want=a000000000000000", S_ARADDR); end
    total++; if (S_ARID !== 4'b0000 || AR_busy !== 1'b1) begin bad++; $display("FAIL single_id_busy id=%b busy=%b want 0000/1", S_ARID, AR_busy); end
    AR_grant_f = '0;
    step();
    total++; if (S_ARVALID !== 2'b00 || AR_busy !== 1'b0 || AR_ready_f !== 2'b00) begin
      bad++; $display("FAIL single_done valid=%b busy=%b ready=%b want 00/0/00", S_ARVALID, AR_busy, AR_ready_f); end
    total++; if (AR_full_f !== 2'b00) begin bad++; $display("FAIL single_full got=%b want=00", AR_full_f); end
  endtask

  // Master 0 holds one read from test_single; a second accepted read must fill it.
  task automatic test_full();
    AR_grant_f = 2'b01; AR_sel_f = 2'b00; S_ARREADY = 2'b11;
    step();
    total++; if (AR_ready_f !== 2'b01) begin bad++; $display("FAIL full_second_ready got=%b want=01", AR_ready_f); end
    AR_grant_f = '0;
    step();
    total++; if (AR_full_f !== 2'b01) begin bad++; $display("FAIL full_set got=%b want=01", AR_full_f); end
    AR_grant_f = 2'b01;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (AR_ready_f !== 2'b00 || AR_busy !== 1'b0) begin
        bad++; $display("FAIL full_grant_ignored ready=%b busy=%b want 00/0", AR_ready_f, AR_busy); end
    end
    AR_grant_f = '0; R_done_f = 2'b01;
    step();
    total++; if (AR_full_f !== 2'b00) begin bad++; $display("FAIL full_clear got=%b want=00", AR_full_f); end
    step();
    R_done_f = '0; S_ARREADY = '0;
  endtask

  task automatic test_stall();
    AR_grant_f = 2'b10; AR_sel_f = 2'b00; AR_id_f = 2'b10; AR_addr_f = {32'h1234_5678, 32'hDEAD_BEEF}; S_ARREADY = 2'b00;
    step();
    total++; if (AR_ready_f !== 2'b10 || S_ARVALID !== 2'b01) begin
      bad++; $display("FAIL stall_start ready=%b valid=%b want 10/01", AR_ready_f, S_ARVALID); end
    AR_grant_f = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (S_ARVALID !== 2'b01 || S_ARID !== 4'b0011 || S_ARADDR !== {32'h0, 32'h1234_5678} || AR_ready_f !== 2'b00) begin
        bad++; $display("FAIL stall_hold valid=%b id=%b addr=%h ready=%b want 01/0011/1234_5678/00", S_ARVALID, S_ARID, S_ARADDR, AR_ready_f); end
    end
    S_ARREADY = 2'b01;
    step();
    total++; if (S_ARVALID !== 2'b00 || AR_busy !== 1'b0) begin bad++; $display("FAIL stall_handshake valid=%b busy=%b want 00/0", S_ARVALID, AR_busy); end
    step();
    total++; if (S_ARVALID !== 2'b00 || AR_full_f !== 2'b00) begin bad++; $display("FAIL stall_single valid=%b full=%b want 00/00", S_ARVALID, AR_full_f); end
    AR_grant_f = 2'b10;
    step();
    AR_grant_f = '0;
    step();
    total++; if (AR_full_f !== 2'b10) begin bad++; $display("FAIL stall_count1 full=%b want=10", AR_full_f); end
    R_done_f = 2'b10; step(); step();
    R_done_f = '0; S_ARREADY = '0;
  endtask

  task automatic test_simul();
    AR_grant_f = 2'b01; AR_sel_f = 2'b00; S_ARREADY = 2'b01;
    step(); AR_grant_f = '0; step();
    AR_grant_f = 2'b01; step();
    AR_grant_f = '0; R_done_f = 2'b01;
    step();
    total++; if (AR_busy !== 1'b0 || AR_full_f !== 2'b00) begin bad++; $display("FAIL simul_edge busy=%b full=%b want 0/00", AR_busy, AR_full_f); end
    R_done_f = '0; AR_grant_f = 2'b01; step();
    AR_grant_f = '0; step();
    total++; if (AR_full_f !== 2'b01) begin bad++; $display("FAIL simul_count_kept full=%b want=01", AR_full_f); end
    R_done_f = 2'b01; step(); step();
    R_done_f = '0; S_ARREADY = '0;
  endtask

  task automatic test_async_reset();
    AR_grant_f = 2'b01; AR_sel_f = 2'b00; S_ARREADY = 2'b01;
    step(); AR_grant_f = '0; step();
    AR_grant_f = 2'b01; step(); AR_grant_f = '0; step();
    total++; if (AR_full_f !== 2'b01) begin bad++; $display("FAIL areset_prefill full=%b want=01", AR_full_f); end
    AR_grant_f = 2'b10; S_ARREADY = 2'b00;
    step();
    AR_grant_f = '0;
    total++; if (S_ARVALID !== 2'b01 || AR_busy !== 1'b1) begin bad++; $display("FAIL areset_issue valid=%b busy=%b want 01/1", S_ARVALID, AR_busy); end
    #2 clr = 1'b0;
    #1;
    total++; if (S_ARVALID !== 2'b00 || AR_busy !== 1'b0 || AR_ready_f !== 2'b00) begin
      bad++; $display("FAIL areset_async valid=%b busy=%b ready=%b want 00/0/00", S_ARVALID, AR_busy, AR_ready_f); end
    total++; if (AR_full_f !== 2'b00 || S_ARADDR !== '0 || S_ARID !== '0) begin
      bad++; $display("FAIL areset_state full=%b addr=%h id=%b want zeros", AR_full_f, S_ARADDR, S_ARID); end
    model_clear();
    @(negedge clk);
    clr = 1'b1;
    step();
    total++; if (S_ARVALID !== 2'b00 || AR_full_f !== 2'b00) begin bad++; $display("FAIL areset_dropped valid=%b full=%b want 00/00", S_ARVALID, AR_full_f); end
  endtask

  task automatic test_timeout();
    logic [S-1:0] ev;
    logic         et;
    AR_grant_f = 2'b01; AR_sel_f = 2'b00; S_ARREADY = 2'b00;
    step();
    AR_grant_f = '0;
    for (int j = 1; j <= TMO + 2; j++) begin
      step();
      ev = (!TMO_EN || j < TMO) ? 2'b01 : 2'b00;
      et = TMO_EN && (j == TMO);
      total++; if (S_ARVALID !== ev || AR_timeout_f !== et) begin
        bad++; $display("FAIL timeout_cycle%0d valid=%b tmo=%b want %b/%b", j, S_ARVALID, AR_timeout_f, ev, et); end
    end
    total++; if (AR_full_f !== 2'b00) begin bad++; $display("FAIL timeout_count full=%b want=00", AR_full_f); end
    S_ARREADY = 2'b01; step();
    S_ARREADY = '0; R_done_f = 2'b01; step();
    R_done_f = '0;
  endtask

  task automatic test_random();
    logic [S-1:0]    ev;
    logic [S*AW-1:0] ea;
    logic [S*IW-1:0] ei;
    logic [M-1:0]    ef;
    for (int c = 0; c < 400; c++) begin
      AR_grant_f = ($urandom_range(0, 1) == 1) ? M'($urandom_range(1, (1 << M) - 1)) : '0;
      AR_sel_f   = (M*SW)'($urandom);
      AR_id_f    = (M*IDW)'($urandom);
      for (int i = 0; i < M; i++) AR_addr_f[i*AW +: AW] = $urandom;
      S_ARREADY  = S'($urandom);
      R_done_f   = ($urandom_range(0, 3) == 0) ? M'($urandom) : '0;
      step();
      ev = '0; ea = '0; ei = '0; ef = '0;
      if (m_busy) begin
        ev[m_sel] = 1'b1;
        ea[m_sel*AW +: AW] = m_addr;
        ei[m_sel*IW +: IW] = IW'((m_mst << IDW) | int'(m_id));
      end
      for (int i = 0; i < M; i++) ef[i] = (m_cnt[i] == NOT);
      total++; if (AR_ready_f !== m_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, AR_ready_f, m_ready); end
      total++; if (S_ARVALID !== ev || AR_busy !== m_busy) begin
        bad++; $display("FAIL rnd_valid c=%0d got=%b/%b want=%b/%b", c, S_ARVALID, AR_busy, ev, m_busy); end
      total++; if (S_ARADDR !== ea || S_ARID !== ei) begin
        bad++; $display("FAIL rnd_payload c=%0d addr=%h id=%b want %h/%b", c, S_ARADDR, S_ARID, ea, ei); end
      total++; if (AR_full_f !== ef || AR_timeout_f !== m_tmo) begin
        bad++; $display("FAIL rnd_full c=%0d full=%b tmo=%b want %b/%b", c, AR_full_f, AR_timeout_f, ef, m_tmo); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_stall();
    test_simul();
    test_async_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ar_issue_mux.md
AR_ISSUE_MUX -- requirements
Module: ar_issue_mux

Interface
REQ-001: Parameter M, default 2, number of masters.
REQ-002: Parameter S, default 2, number of slaves.
REQ-003: Parameter NUM_OUTSTANDING_TRANS, default 2, per-master read outstanding limit; IDW = $clog2(NUM_OUTSTANDING_TRANS).
REQ-004: Parameter ADDR_WIDTH, default 32, address width; MW = $clog2(M).
REQ-005: Parameter TIMEOUT, default 16, issue watchdog limit in cycles (used only under REQ-026).
REQ-006: clk  input  1  single clock; all state changes on its rising edge.
REQ-007: clr  input  1  reset, asynchronous, active-low.
REQ-008: AR_grant_f  input  M  one-hot grant from read_arbiter.
REQ-009: AR_sel_f  input  M*$clog2(S)  per-master slave select from read_arbiter.
REQ-010: AR_addr_f / AR_id_f  input  M*ADDR_WIDTH / M*IDW  per-master address and ID payloads.
REQ-011: R_done_f  input  M  one-cycle pulse per completed read (last beat returned) per master.
REQ-012: AR_ready_f  output  M  one-cycle accept pulse to the granted master.
REQ-013: S_ARVALID / S_ARREADY  output / input  S  slave AR handshake.
REQ-014: S_ARADDR / S_ARID  output  S*ADDR_WIDTH / S*(MW+IDW)  slave payload; ARID = {master index, master ID}.
REQ-015: AR_full_f  output  M  master has NUM_OUTSTANDING_TRANS reads outstanding (masks arbiter requests).
REQ-016: AR_busy / AR_timeout_f  output  1 / 1  ISSUE state active; watchdog drop pulse.

Function
REQ-017: FSM states IDLE, ISSUE; IDLE->ISSUE on load (REQ-018); ISSUE->IDLE on S_ARREADY[sel] while S_ARVALID[sel] high, or on timeout (REQ-026).
REQ-018: Load: in IDLE, edge with AR_grant_f[i]=1 and AR_full_f[i]=0 registers i, AR_sel_f[i], AR_addr_f[i], AR_id_f[i]; multiple grant bits -> lowest index.
REQ-019: AR_ready_f[i] high exactly in the cycle after the load edge (registered), low otherwise.
REQ-020: In ISSUE, S_ARVALID[sel]=1 from first ISSUE cycle; payload held stable until handshake; unselected slaves ARVALID=0, ARADDR=0, ARID=0.
REQ-021: Grant latency: grant sampled at edge N -> AR_ready_f and S_ARVALID high in cycle N+1; handshake at edge K -> IDLE in cycle K+1; max throughput one request per 2 cycles.
REQ-022: Grants arriving in ISSUE, or for a full master, are ignored (no load, no ready pulse).
REQ-023: Per-master outstanding counter (width $clog2(NUM_OUTSTANDING_TRANS+1)): +1 on slave handshake for that master, -1 on R_done_f[i]; simultaneous -> unchanged; decrement at 0 ignored; never exceeds NUM_OUTSTANDING_TRANS.
REQ-024: AR_full_f[i] = (count[i] == NUM_OUTSTANDING_TRANS), combinational from register.

Reset
REQ-025: clr=0 asynchronously forces IDLE, all counters 0, payload registers 0, all outputs 0, including mid-ISSUE (transaction dropped, no count change).

Configuration
REQ-026: Macro AR_ISSUE_TIMEOUT_EN defined: cycle counter runs in ISSUE; after TIMEOUT ISSUE cycles without handshake, S_ARVALID drops, FSM -> IDLE, AR_timeout_f pulses one cycle, counter not incremented.
REQ-027: Macro undefined: no watchdog logic, ISSUE waits indefinitely, AR_timeout_f tied 0.

Verification
REQ-028: Grant=01, sel0=1, addr0=A000_0000, id0=0, S_ARREADY[1]=1 -> AR_ready_f=01 one cycle, S_ARVALID=10, S_ARADDR[slave1]=A000_0000, S_ARID[slave1]=0, count0=1.
REQ-029: Grant=10, sel1=0, id1=1, S_ARREADY low 3 cycles -> ARVALID/payload ({1,1}=3) held 3+ cycles, single handshake, count1=1.
REQ-030: Two accepted master-0 reads, no R_done -> AR_full_f=01, further grant=01 yields no ready pulse; R_done_f=01 -> AR_full_f=00.
REQ-031: Handshake and R_done_f for same master same cycle at count=1 -> count stays 1.
REQ-032: clr low during ISSUE -> S_ARVALID=0 immediately (async), counts 0, AR_busy=0.
REQ-033: With AR_ISSUE_TIMEOUT_EN, S_ARREADY held 0 -> AR_timeout_f pulse after 16 ISSUE cycles, count unchanged; without macro ARVALID stays high.
